// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide: 32 shift-add / restoring-divide steps, then one fix-up cycle.
// Busy is high for 33 cycles and Done pulses 34 edges after Start; Start is ignored while Busy, and Flush aborts the op.
module ex_muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            Start,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] Operand_A,
  input  logic [XLEN-1:0] Operand_B,
  input  logic            Flush,
  output logic            Busy,
  output logic            Done,
  output logic [XLEN-1:0] Result
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_f3;
  logic              r_a_neg;
  logic              r_b_neg;
  logic [XLEN-1:0]   r_a_mag;
  logic [XLEN-1:0]   r_b_mag;
  logic [XLEN-1:0]   r_a_raw;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;
  logic [XLEN-1:0]   r_res;
  logic              r_pend;

  logic              w_a_sgn;
  logic              w_b_sgn;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic [XLEN:0]     w_madd;
  logic [XLEN:0]     w_shift;
  logic              w_ge;
  logic [XLEN-1:0]   w_diff;
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_s;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic              w_div0;
  logic [XLEN-1:0]   w_fix_res;

  assign w_a_sgn = (Funct3 == 3'b001) || (Funct3 == 3'b010) ||
                   (Funct3 == 3'b100) || (Funct3 == 3'b110);
  assign w_b_sgn = (Funct3 == 3'b001) || (Funct3 == 3'b100) || (Funct3 == 3'b110);
  assign w_a_neg = w_a_sgn & Operand_A[XLEN-1];
  assign w_b_neg = w_b_sgn & Operand_B[XLEN-1];
  assign w_a_mag = w_a_neg ? -Operand_A : Operand_A;
  assign w_b_mag = w_b_neg ? -Operand_B : Operand_B;

  // Multiply: {r_hi, r_lo} holds partial product above the not-yet-consumed multiplier bits.
  assign w_madd  = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_a_mag : {XLEN{1'b0}})};

  // Divide: r_hi is the partial remainder, r_lo shifts dividend bits out and quotient bits in.
  assign w_shift = {r_hi, r_lo[XLEN-1]};
  assign w_ge    = (w_shift >= {1'b0, r_b_mag});
  assign w_diff  = w_shift[XLEN-1:0] - r_b_mag;

  assign w_prod   = {r_hi, r_lo};
  assign w_prod_s = (r_a_neg ^ r_b_neg) ? -w_prod : w_prod;
  assign w_quo    = (r_a_neg ^ r_b_neg) ? -r_lo : r_lo;
  assign w_rem    = r_a_neg ? -r_hi : r_hi;
  assign w_div0   = (r_b_mag == {XLEN{1'b0}});

  always_comb begin
    w_fix_res = '0;
    case (r_f3)
      3'b000:                 w_fix_res = w_prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_fix_res = w_prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_fix_res = w_div0 ? {XLEN{1'b1}} : w_quo;
      default:                w_fix_res = w_div0 ? r_a_raw : w_rem;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_f3    <= '0;
      r_a_neg <= 1'b0;
      r_b_neg <= 1'b0;
      r_a_mag <= '0;
      r_b_mag <= '0;
      r_a_raw <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_res   <= '0;
      r_pend  <= 1'b0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      Result  <= '0;
    end else begin
      // Result and Done are published one cycle after FIX so Done follows the Busy drop.
      Done   <= r_pend;
      r_pend <= 1'b0;
      if (r_pend) Result <= r_res;

      case (r_state)
        IDLE: begin
          if (Start && !Flush) begin
            r_f3    <= Funct3;
            r_a_neg <= w_a_neg;
            r_b_neg <= w_b_neg;
            r_a_mag <= w_a_mag;
            r_b_mag <= w_b_mag;
            r_a_raw <= Operand_A;
            r_hi    <= '0;
            r_lo    <= Funct3[2] ? w_a_mag : w_b_mag;
            r_cnt   <= '0;
            Busy    <= 1'b1;
            r_state <= CALC;
          end
        end
        CALC: begin
          if (Flush) begin
            Busy    <= 1'b0;
            r_state <= IDLE;
          end else begin
            if (r_f3[2]) begin
              r_hi <= w_ge ? w_diff : w_shift[XLEN-1:0];
              r_lo <= {r_lo[XLEN-2:0], w_ge};
            end else begin
              r_hi <= w_madd[XLEN:1];
              r_lo <= {w_madd[0], r_lo[XLEN-1:1]};
            end
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == {CNT_W{1'b1}}) r_state <= FIX;
          end
        end
        FIX: begin
          if (!Flush) begin
            r_res  <= w_fix_res;
            r_pend <= 1'b1;
          end
          Busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          Busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed-vector bench for ex_muldiv_unit: results, 34-edge latency, 33-cycle Busy, flush, reset and Start filtering.
module tb_ex_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        Start;
  logic [2:0]  Funct3;
  logic [31:0] Operand_A;
  logic [31:0] Operand_B;
  logic        Flush;
  logic        Busy;
  logic        Done;
  logic [31:0] Result;

  int total = 0;
  int bad   = 0;

  ex_muldiv_unit #(.XLEN(32), .CNT_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Start     (Start),
    .Funct3    (Funct3),
    .Operand_A (Operand_A),
    .Operand_B (Operand_B),
    .Flush     (Flush),
    .Busy      (Busy),
    .Done      (Done),
    .Result    (Result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called 1 time unit after a rising edge; returns 1 time unit after the sampling edge.
  task automatic launch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    Funct3    = f3;
    Operand_A = a;
    Operand_B = b;
    Start     = 1'b1;
    @(posedge clk);
    #1;
    Start     = 1'b0;
    Operand_A = $urandom;
    Operand_B = $urandom;
    Funct3    = 3'($urandom_range(0, 7));
  endtask

  task automatic wait_done(input logic [31:0] exp, input string tag);
    int n  = 0;
    int nb = Busy ? 1 : 0;
    while (!Done && n < 60) begin
      @(posedge clk);
      #1;
      n++;
      if (Busy) nb++;
    end
    chk({tag, "_lat"}, n, 34);
    chk({tag, "_busy"}, nb, 33);
    chk({tag, "_res"}, Result, exp);
  endtask

  task automatic run(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input string tag);
    launch(f3, a, b);
    wait_done(exp, tag);
    @(posedge clk);
    #1;
    chk({tag, "_done1"}, Done, 1'b0);
  endtask

  task automatic no_done(input int cycles, input string tag);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (Done) seen++;
    end
    chk(tag, seen, 0);
  endtask

  initial begin
    int dones;
    rst_n     = 1'b1;
    Start     = 1'b0;
    Flush     = 1'b0;
    Funct3    = 3'b000;
    Operand_A = '0;
    Operand_B = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", Busy, 1'b0);
    chk("rst_done", Done, 1'b0);
    chk("rst_res", Result, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu");

    // Asynchronous reset in the middle of CALC
    launch(3'b101, 32'd100, 32'd7);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", Busy, 1'b0);
    chk("midrst_done", Done, 1'b0);
    chk("midrst_res", Result, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    no_done(40, "midrst_nodone");

    run(3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, "mul");
    run(3'b001, 32'h80000000, 32'h80000000, 32'h40000000, "mulh");
    run(3'b010, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, "mulhsu");
    run(3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, "div_neg");
    run(3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, "rem_neg");
    run(3'b101, 32'd100, 32'd7, 32'd14, "divu");
    run(3'b111, 32'd100, 32'd7, 32'd2, "remu");
    run(3'b101, 32'd5, 32'd0, 32'hFFFFFFFF, "divu_by0");
    run(3'b110, 32'd5, 32'd0, 32'd5, "rem_by0");
    run(3'b100, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, "div_neg_by0");
    run(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div_ovf");
    run(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0, "rem_ovf");

    // Flush at CALC cycle 10: op abandoned, Result keeps 0 from rem_ovf... use a nonzero prior
    run(3'b111, 32'd100, 32'd7, 32'd2, "pre_flush");
    launch(3'b100, 32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    #1;
    Flush = 1'b1;
    @(posedge clk);
    #1;
    Flush = 1'b0;
    chk("flush_busy", Busy, 1'b0);
    no_done(40, "flush_nodone");
    chk("flush_res", Result, 32'd2);

    // Flush and Start together in IDLE: no launch
    Funct3    = 3'b000;
    Operand_A = 32'd3;
    Operand_B = 32'd3;
    Start     = 1'b1;
    Flush     = 1'b1;
    @(posedge clk);
    #1;
    Start = 1'b0;
    Flush = 1'b0;
    chk("flushstart_busy", Busy, 1'b0);
    no_done(40, "flushstart_nodone");
    chk("flushstart_res", Result, 32'd2);

    // Start pulses while Busy are ignored
    launch(3'b000, 32'd6, 32'd7);
    dones = 0;
    for (int i = 0; i < 80; i++) begin
      Start = (i == 5) || (i == 20);
      Operand_A = 32'd9;
      Operand_B = 32'd9;
      @(posedge clk);
      #1;
      if (Done) dones++;
    end
    Start = 1'b0;
    chk("multistart_dones", dones, 1);
    chk("multistart_res", Result, 32'd42);
    chk("multistart_busy", Busy, 1'b0);

    // Back-to-back: second Start asserted during the Done cycle
    launch(3'b011, 32'h00010000, 32'h00010000);
    wait_done(32'h00000001, "b2b_first");
    launch(3'b111, 32'd100, 32'd7);
    chk("b2b_accept_busy", Busy, 1'b1);
    chk("b2b_done_drop", Done, 1'b0);
    wait_done(32'd2, "b2b_second");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
Iterative RV32M multiply/divide unit in the EX stage, directly downstream of the operand-B select mux. The mux output (register data for R-type) arrives on Operand_B. Operand_A comes from the ID/EX register. The unit is started for M-extension R-type ops, holds Busy so the hazard unit stalls IF/ID/EX, and returns a registered 32-bit result with a one-cycle Done pulse.

Parameters:
XLEN, 32, operand/result width; only 32 is supported.
CNT_W, 5, iteration counter width; must satisfy 2**CNT_W == XLEN.

Ports:
clk  input  1  pipeline clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
Start  input  1  launch request, sampled only in IDLE.
Funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
Operand_A  input  32  rs1 value from ID/EX.
Operand_B  input  32  rs2 value from the operand-B select mux.
Flush  input  1  abort the in-flight op (branch/exception flush).
Busy  output  1  op in progress; stall request to the hazard unit.
Done  output  1  one-cycle pulse; Result valid from this cycle.
Result  output  32  registered result; holds until the next Done or reset.

Behaviour:
- Clock/reset: one clock, clk. rst_n is asynchronous and active-low. On reset: state=IDLE, Busy=0, Done=0, Result=0, all internal registers 0. Reset mid-operation abandons the op with no Done.
- States:
  - IDLE: on Start=1 and Flush=0, latch Funct3, signs and operand magnitudes. Signedness: A is signed for MULH, MULHSU, DIV, REM. B is signed for MULH, DIV, REM. Clear counter, go to CALC.
  - CALC: one shift-add step (multiply) or restoring shift-subtract step (divide) per cycle. Counter increments. After 32 steps (counter==31), go to FIX.
  - FIX: apply sign correction and special cases, register Result, assert Done for the next cycle, return to IDLE.
- Timing:
  - Busy=1 exactly while state is CALC or FIX: 33 cycles, rising the cycle after Start is sampled.
  - Done=1 for exactly one cycle, the first cycle after Busy falls.
  - Fixed latency: 34 rising edges from the Start-sampling edge to the edge that asserts Done.
  - Latency is identical for every op and every operand value, including special cases.
- Multiply:
  - 64-bit unsigned product of magnitudes; negate if exactly one operand is treated as negative.
  - MUL returns product[31:0]. MULH, MULHSU and MULHU return product[63:32].
- Divide:
  - Unsigned quotient/remainder of magnitudes.
  - The quotient is negated if the operand signs differ (signed ops).
  - The remainder takes the dividend's sign.
  - DIV/DIVU return the quotient. REM/REMU return the remainder.
- Divide by zero (B==0): quotient=0xFFFFFFFF, remainder=Operand_A, for both signed and unsigned.
- Signed overflow (DIV/REM, A=0x80000000, B=0xFFFFFFFF): quotient=0x80000000, remainder=0.
- Start while Busy=1 is ignored; it does not queue.
- Start in the same cycle as Done (state IDLE) is accepted normally.
- Flush=1 in CALC or FIX: next state is IDLE. Busy drops next cycle, no Done, Result unchanged.
- Flush=1 with Start=1 in IDLE: Flush wins; no launch.
- Operand_A, Operand_B and Funct3 may change after the Start-sampling edge without affecting the result.

Test Plan:
- Reset mid-CALC (rst_n low 2 cycles) -> Busy=0, Done=0, Result=0 immediately. Then MUL 7 x 0xFFFFFFFD -> Result=0xFFFFFFEB, Done exactly 34 edges after Start, Busy high for 33 cycles.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 0x00000002 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100 / 7 -> 14. REMU same -> 2.
- DIVU 5 / 0 -> 0xFFFFFFFF. REM 5 / 0 -> 5. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM same -> 0. Each with latency 34.
- Start DIV, Flush at cycle 10 of CALC -> Busy low next cycle, no Done, Result keeps prior value. Flush+Start together in IDLE -> no launch. Start pulses during Busy -> ignored, exactly one Done.
- Back-to-back: second Start asserted in the Done cycle -> accepted; second Done 34 edges later with the correct value; operands changed after sampling do not affect the result.
